// File: rtl/uart_bus_bridge_pkg.sv
// Shared definitions for the UART-to-peripheral-bus bridge: command opcodes,
// FSM state encoding, the peripheral register map and a byte-shift helper.
package uart_bus_bridge_pkg;

    // Command opcodes as received from the host
    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_BUS_WR = 3'd3,
        ST_BUS_RD = 3'd4,
        ST_RESP   = 3'd5
    } bridge_state_t;

    // Peripheral register map reachable through the bridge
    localparam logic [31:0] ADDR_TIMER_CTRL  = 32'h4000_0000;
    localparam logic [31:0] ADDR_TIMER_COUNT = 32'h4000_0004;
    localparam logic [31:0] ADDR_TIMER_CMP   = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED         = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGIT_LO    = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGIT_HI    = 32'h4000_0014;
    localparam logic [31:0] ADDR_UART_DATA   = 32'h4000_0018;
    localparam logic [31:0] ADDR_UART_STATUS = 32'h4000_001C;
    localparam logic [31:0] ADDR_UART_CTRL   = 32'h4000_0020;

    // Big-endian field assembly: shift the word up one byte and append b
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  b);
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/uart_bus_bridge_resp_shifter.sv
// Response register for the bridge: holds up to four bytes, presents them
// MSB first on a valid/ready output stage, and reports the final handshake.
module uart_bus_bridge_resp_shifter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_word,
    input  logic [31:0] i_word,
    input  logic        i_load_byte,
    input  logic [7:0]  i_byte,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_valid,
    output logic        o_last_done
);

    // Slot 0 is the byte currently offered; higher slots follow it
    logic [3:0][7:0] r_slots;
    logic [3:0][7:0] w_slots_next;
    logic [2:0]      r_count;
    logic            w_advance;

    assign o_tx_valid  = (r_count != 3'd0);
    assign w_advance   = o_tx_valid && i_tx_ready;
    assign o_last_done = w_advance && (r_count == 3'd1);
    assign o_tx_byte   = r_slots[0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [7:0] w_follow;
            logic [7:0] w_single;

            // Each slot takes its successor on a handshake; the tail refills with zero
            if (gi == 3) begin : g_tail
                assign w_follow = 8'h00;
            end else begin : g_body
                assign w_follow = r_slots[gi+1];
            end

            // A single-byte response sits in the head slot only
            if (gi == 0) begin : g_head
                assign w_single = i_byte;
            end else begin : g_rest
                assign w_single = 8'h00;
            end

            assign w_slots_next[gi] = i_load_word ? i_word[31-8*gi -: 8] :
                                      i_load_byte ? w_single :
                                      w_advance   ? w_follow :
                                                    r_slots[gi];
        end
    endgenerate

    // Byte storage register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slots <= '0;
        end else begin
            r_slots <= w_slots_next;
        end
    end

    // Remaining byte count: loads set it, each accepted byte decrements it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 3'd0;
        end else if (i_load_word) begin
            r_count <= 3'd4;
        end else if (i_load_byte) begin
            r_count <= 3'd1;
        end else if (w_advance) begin
            r_count <= r_count - 3'd1;
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command bridge: parses 'W'/'R' commands from a received byte stream,
// performs the matching peripheral bus access and returns a response.
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned WR_HOLD  = 4,
    parameter int unsigned TIMEOUT  = 50000000,
    parameter logic [7:0]  ACK_BYTE = 8'h4B,
    parameter logic [7:0]  ERR_BYTE = 8'h3F
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned GAP_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);

    bridge_state_t     r_state;
    bridge_state_t     w_state_next;

    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_is_write;
    logic [1:0]        r_byte_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_overrun;
    logic              r_rd;
    logic              r_wr;

    logic              w_latch_op;
    logic              w_addr_shift;
    logic              w_data_shift;
    logic              w_discard;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_gap_clr;
    logic              w_gap_inc;
    logic              w_hold_clr;
    logic              w_hold_inc;
    logic              w_load_word;
    logic              w_load_byte;
    logic [7:0]        w_resp_byte;
    logic              w_set_overrun;
    logic              w_resp_done;

    assign addr    = r_addr;
    assign wdata   = r_wdata;
    assign rd      = r_rd;
    assign wr      = r_wr;
    assign overrun = r_overrun;
    assign busy    = (r_state != ST_IDLE);

    // FSM state register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_next  = r_state;
        w_latch_op    = 1'b0;
        w_addr_shift  = 1'b0;
        w_data_shift  = 1'b0;
        w_discard     = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_gap_clr     = 1'b0;
        w_gap_inc     = 1'b0;
        w_hold_clr    = 1'b0;
        w_hold_inc    = 1'b0;
        w_load_word   = 1'b0;
        w_load_byte   = 1'b0;
        w_resp_byte   = ACK_BYTE;
        w_set_overrun = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_clr  = 1'b1;
                w_gap_clr  = 1'b1;
                w_hold_clr = 1'b1;
                if (rx_valid) begin
                    if ((rx_byte == OP_WRITE) || (rx_byte == OP_READ)) begin
                        w_latch_op   = 1'b1;
                        w_state_next = ST_ADDR;
                    end else begin
                        w_load_byte  = 1'b1;
                        w_resp_byte  = ERR_BYTE;
                        w_state_next = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                if (rx_valid) begin
                    w_addr_shift = 1'b1;
                    w_gap_clr    = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = r_is_write ? ST_DATA : ST_BUS_RD;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_discard    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end

            ST_DATA: begin
                if (rx_valid) begin
                    w_data_shift = 1'b1;
                    w_gap_clr    = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = ST_BUS_WR;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_discard    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end

            ST_BUS_WR: begin
                w_set_overrun = rx_valid;
                if (r_hold_cnt == HOLD_LAST) begin
                    w_hold_clr   = 1'b1;
                    w_load_byte  = 1'b1;
                    w_resp_byte  = ACK_BYTE;
                    w_state_next = ST_RESP;
                end else begin
                    w_hold_inc = 1'b1;
                end
            end

            ST_BUS_RD: begin
                // rdata is valid this cycle; the shifter captures it at the edge
                w_set_overrun = rx_valid;
                w_load_word   = 1'b1;
                w_state_next  = ST_RESP;
            end

            ST_RESP: begin
                w_set_overrun = rx_valid;
                if (w_resp_done) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Opcode latch and big-endian address/data assembly
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_is_write <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
        end else begin
            if (w_latch_op) begin
                r_is_write <= (rx_byte == OP_WRITE);
            end
            if (w_discard) begin
                r_addr  <= 32'h0;
                r_wdata <= 32'h0;
            end else begin
                if (w_addr_shift) begin
                    r_addr <= shift_in_byte(r_addr, rx_byte);
                end
                if (w_data_shift) begin
                    r_wdata <= shift_in_byte(r_wdata, rx_byte);
                end
            end
        end
    end

    // Field byte counter, inter-byte gap counter and write hold counter
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= 2'd0;
            r_gap_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_byte_cnt <= 2'd0;
            end else if (w_cnt_inc) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_gap_clr) begin
                r_gap_cnt <= '0;
            end else if (w_gap_inc) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
            if (w_hold_clr) begin
                r_hold_cnt <= '0;
            end else if (w_hold_inc) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // Registered bus strobes, asserted exactly while in the bus states
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
        end else begin
            r_rd <= (w_state_next == ST_BUS_RD);
            r_wr <= (w_state_next == ST_BUS_WR);
        end
    end

    // Sticky flag for bytes that arrive while the bridge cannot take them
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_set_overrun) begin
            r_overrun <= 1'b1;
        end
    end

    uart_bus_bridge_resp_shifter u_resp_shifter (
        .i_clk       (sysclk),
        .i_rst       (reset),
        .i_load_word (w_load_word),
        .i_word      (rdata),
        .i_load_byte (w_load_byte),
        .i_byte      (w_resp_byte),
        .i_tx_ready  (tx_ready),
        .o_tx_byte   (tx_byte),
        .o_tx_valid  (tx_valid),
        .o_last_done (w_resp_done)
    );

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: a command-level model predicts bus
// accesses and response bytes; a negedge monitor checks the DUT every cycle.
module tb_uart_bus_bridge;
    import uart_bus_bridge_pkg::*;

    localparam int unsigned WR_HOLD  = 4;
    localparam int unsigned TIMEOUT  = 40;
    localparam logic [7:0]  ACK_BYTE = 8'h4B;
    localparam logic [7:0]  ERR_BYTE = 8'h3F;

    logic        sysclk;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        overrun;

    uart_bus_bridge #(
        .WR_HOLD  (WR_HOLD),
        .TIMEOUT  (TIMEOUT),
        .ACK_BYTE (ACK_BYTE),
        .ERR_BYTE (ERR_BYTE)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Peripheral contents seen by reads
    function automatic logic [31:0] periph_read(input logic [31:0] a);
        case (a)
            ADDR_TIMER_COUNT: return 32'h1234_5678;
            ADDR_DIGIT_LO:    return 32'hCAFE_F00D;
            default:          return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign rdata = rd ? periph_read(addr) : 32'h0;

    // Model state: pending command bytes and expected DUT activity
    logic [7:0]  cmd_q[$];
    logic [7:0]  exp_tx[$];
    logic        exp_op_wr[$];
    logic [31:0] exp_op_addr[$];
    logic [31:0] exp_op_data[$];
    logic        exp_overrun;

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Command interpreter: consumes one accepted byte, emits expectations
    task automatic model_rx(input logic [7:0] b);
        logic [31:0] a;
        logic [31:0] d;
        cmd_q.push_back(b);
        if (cmd_q[0] != 8'h57 && cmd_q[0] != 8'h52) begin
            exp_tx.push_back(ERR_BYTE);
            cmd_q.delete();
        end else if (cmd_q[0] == 8'h57 && cmd_q.size() == 9) begin
            a = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]};
            d = {cmd_q[5], cmd_q[6], cmd_q[7], cmd_q[8]};
            exp_op_wr.push_back(1'b1);
            exp_op_addr.push_back(a);
            exp_op_data.push_back(d);
            exp_tx.push_back(ACK_BYTE);
            cmd_q.delete();
        end else if (cmd_q[0] == 8'h52 && cmd_q.size() == 5) begin
            a = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]};
            d = periph_read(a);
            exp_op_wr.push_back(1'b0);
            exp_op_addr.push_back(a);
            exp_op_data.push_back(32'h0);
            for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
            cmd_q.delete();
        end
    endtask

    task automatic clear_model();
        cmd_q.delete();
        exp_tx.delete();
        exp_op_wr.delete();
        exp_op_addr.delete();
        exp_op_data.delete();
    endtask

    // Drive one byte for one cycle; called at posedge+1
    task automatic send_byte(input logic [7:0] b, input bit use_model);
        if (use_model) model_rx(b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge sysclk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
    endtask

    // Wait (bounded) for all expected activity to drain, then require idle
    task automatic wait_done(input string name, input int max_cycles);
        int k;
        k = 0;
        while ((exp_tx.size() != 0 || exp_op_wr.size() != 0) && k < max_cycles) begin
            @(posedge sysclk);
            #1;
            k++;
        end
        chk({name, "_drained"}, exp_tx.size() + exp_op_wr.size(), 0);
        @(posedge sysclk);
        #1;
        chk({name, "_busy_after"}, busy, 1'b0);
    endtask

    // Cycle monitor state
    logic       prev_wr, prev_rd, prev_stall, prev_acc;
    logic [7:0] prev_byte;
    int         wr_run, rd_run;
    logic       allow_wr, allow_rd;

    // Per-cycle comparison against the model
    initial begin
        prev_wr = 1'b0; prev_rd = 1'b0; prev_stall = 1'b0; prev_acc = 1'b0;
        prev_byte = 8'h00; wr_run = 0; rd_run = 0;
        forever begin
            @(negedge sysclk);
            if (reset) begin
                prev_wr = 1'b0; prev_rd = 1'b0; prev_stall = 1'b0; prev_acc = 1'b0;
                wr_run = 0; rd_run = 0;
            end else begin
                allow_wr = (exp_op_wr.size() > 0) && exp_op_wr[0];
                allow_rd = (exp_op_wr.size() > 0) && !exp_op_wr[0];
                chk("rd_wr_exclusive", rd && wr, 1'b0);
                chk("overrun", overrun, exp_overrun);
                chk("wr_unexpected", wr && !allow_wr, 1'b0);
                chk("rd_unexpected", rd && !allow_rd, 1'b0);
                if (wr && allow_wr) begin
                    chk("wr_addr", addr, exp_op_addr[0]);
                    chk("wr_data", wdata, exp_op_data[0]);
                    wr_run++;
                end else if (prev_wr) begin
                    chk("wr_len", wr_run, WR_HOLD);
                    wr_run = 0;
                    if (exp_op_wr.size() > 0) begin
                        void'(exp_op_wr.pop_front());
                        void'(exp_op_addr.pop_front());
                        void'(exp_op_data.pop_front());
                    end
                end
                if (rd && allow_rd) begin
                    chk("rd_addr", addr, exp_op_addr[0]);
                    rd_run++;
                end else if (prev_rd) begin
                    chk("rd_len", rd_run, 1);
                    rd_run = 0;
                    if (exp_op_wr.size() > 0) begin
                        void'(exp_op_wr.pop_front());
                        void'(exp_op_addr.pop_front());
                        void'(exp_op_data.pop_front());
                    end
                end
                if (prev_stall) begin
                    chk("tx_hold_valid", tx_valid, 1'b1);
                    chk("tx_hold_byte", tx_byte, prev_byte);
                end
                if (prev_acc) chk("tx_valid_next", tx_valid, exp_tx.size() != 0);
                chk("tx_unexpected", tx_valid && (exp_tx.size() == 0), 1'b0);
                if (tx_valid && tx_ready && exp_tx.size() > 0) begin
                    chk("tx_byte", tx_byte, exp_tx.pop_front());
                end
                prev_stall = tx_valid && !tx_ready;
                prev_acc   = tx_valid && tx_ready;
                prev_byte  = tx_byte;
                prev_wr    = wr && allow_wr;
                prev_rd    = rd && allow_rd;
            end
        end
    end

    // Directed stimulus
    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        tx_ready = 1'b1;
        exp_overrun = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_rd", rd, 1'b0);
        chk("reset_wr", wr, 1'b0);
        chk("reset_addr", addr, 32'h0);
        chk("reset_wdata", wdata, 32'h0);
        chk("reset_tx_byte", tx_byte, 8'h00);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        reset = 1'b0;
        @(posedge sysclk);
        #1;

        // Write 0xA5 to the LED register
        send_write(32'h4000_000C, 32'h0000_00A5);
        chk("write_wr_high", wr, 1'b1);
        chk("write_addr_lit", addr, 32'h4000_000C);
        chk("write_data_lit", wdata, 32'h0000_00A5);
        wait_done("write", 200);

        // Read the timer count with the transmitter always ready
        send_read(32'h4000_0004);
        chk("model_read_len", exp_tx.size(), 4);
        chk("model_read_b0", exp_tx[0], 8'h12);
        chk("model_read_b1", exp_tx[1], 8'h34);
        chk("model_read_b2", exp_tx[2], 8'h56);
        chk("model_read_b3", exp_tx[3], 8'h78);
        chk("read_rd_high", rd, 1'b1);
        chk("read_addr_lit", addr, 32'h4000_0004);
        wait_done("read", 200);

        // Read with the transmitter stalled 20 cycles before each byte
        tx_ready = 1'b0;
        send_read(ADDR_DIGIT_LO);
        for (int n = 0; n < 4; n++) begin
            repeat (20) @(posedge sysclk);
            #1;
            tx_ready = 1'b1;
            @(posedge sysclk);
            #1;
            tx_ready = 1'b0;
        end
        tx_ready = 1'b1;
        wait_done("backpressure", 200);

        // Unknown opcode; a byte arriving on the final handshake is dropped
        tx_ready = 1'b0;
        send_byte(8'h41, 1'b1);
        repeat (3) @(posedge sysclk);
        #1;
        chk("err_byte_lit", tx_byte, 8'h3F);
        tx_ready = 1'b1;
        rx_byte  = 8'h52;
        rx_valid = 1'b1;
        @(posedge sysclk);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        exp_overrun = 1'b1;
        chk("drop_on_exit_busy", busy, 1'b0);
        wait_done("err_exit", 50);

        // Unknown opcode with a byte injected mid-response
        tx_ready = 1'b0;
        send_byte(8'h00, 1'b1);
        send_byte(8'h57, 1'b0);
        chk("resp_state_kept", busy, 1'b1);
        repeat (2) @(posedge sysclk);
        #1;
        tx_ready = 1'b1;
        wait_done("err_inject", 50);

        // Abandoned write times out, then a read completes normally
        send_byte(8'h57, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TIMEOUT - 2) @(posedge sysclk);
        #1;
        chk("timeout_not_yet", busy, 1'b1);
        repeat (3) @(posedge sysclk);
        #1;
        chk("timeout_idle", busy, 1'b0);
        cmd_q.delete();
        send_read(ADDR_UART_CTRL);
        wait_done("after_timeout", 200);

        // Reset during the second write cycle
        send_write(ADDR_TIMER_CMP, 32'hDEAD_BEEF);
        chk("rst_test_wr_high", wr, 1'b1);
        @(posedge sysclk);
        #2;
        reset = 1'b1;
        exp_overrun = 1'b0;
        clear_model();
        #1;
        chk("rst_wr_drop", wr, 1'b0);
        chk("rst_rd", rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_overrun", overrun, 1'b0);
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        @(posedge sysclk);
        #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_wr", wr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
